// File: rtl/snn_spike_tx.sv
// Framed byte streamer for snn_core spike rows: A5, ts lo, ts hi, NB payload bytes per row.
// Latency: row strobed at edge E0 into an idle, empty block shows 0xA5 from E1; one byte/clock.
// Backpressure: out_ready low holds out_data/out_valid; full FIFO drops rows (SNN_TX_SKIP_EMPTY_EN skips zero rows).
module snn_spike_tx #(
   parameter int N     = 96,
   parameter int DEPTH = 4,
   parameter int TSW   = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  spikes_vec,
   input  logic          spike_valid,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          overflow,
   output logic [15:0]   drop_cnt,
   input  logic          clr_stat
);
   localparam int NB = N / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int EW = TSW + N;
   localparam logic [7:0]     SYNC     = 8'hA5;
   localparam logic [AW:0]    CNT_FULL = DEPTH;
   localparam logic [AW:0]    CNT_ONE  = 1;
   localparam logic [AW-1:0]  PTR_ONE  = 1;
   localparam logic [IW-1:0]  IDX_LAST = NB - 1;
   localparam logic [IW-1:0]  IDX_ONE  = 1;
   localparam logic [TSW-1:0] TS_ONE   = 1;

   typedef enum logic [2:0] {IDLE, HDR, TS0, TS1, PAY} state_t;

   state_t         state;
   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic [IW-1:0]  idx;
   logic [TSW-1:0] ts;

   logic [TSW-1:0] head_ts;
   logic [N-1:0]   head_row;
   logic [7:0]     pay [NB];
   logic           accept;
   logic           pop;
   logic           keep;
   logic           space;
   logic           push;
   logic           drop;
   logic           more;

   assign {head_ts, head_row} = mem[rd_ptr];

   always_comb begin
      for (int k = 0; k < NB; k++) begin
         pay[k] = head_row[8*k +: 8];
      end
   end

`ifdef SNN_TX_SKIP_EMPTY_EN
   assign keep = |spikes_vec;
`else
   assign keep = 1'b1;
`endif

   assign accept = out_valid && out_ready;
   // The head is only released once its final byte has left, so a frame never loses its source.
   assign pop    = accept && (state == PAY) && (idx == IDX_LAST);
   assign space  = (count < CNT_FULL) || pop;
   assign push   = spike_valid && keep && space;
   assign drop   = spike_valid && keep && !space;
   // Another frame is ready after this pop if one was queued behind the head or arrives now.
   assign more   = (count > CNT_ONE) || push;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {ts, spikes_vec};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ts       <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (spike_valid) begin
            ts <= ts + TS_ONE;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_stat) begin
            overflow <= 1'b0;
         end
         // A drop in the clear cycle still counts as the first drop after the clear.
         if (clr_stat) begin
            drop_cnt <= drop ? 16'd1 : 16'd0;
         end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state     <= HDR;
                  out_valid <= 1'b1;
                  out_data  <= SYNC;
               end
            end
            HDR: begin
               if (accept) begin
                  state    <= TS0;
                  out_data <= head_ts[7:0];
               end
            end
            TS0: begin
               if (accept) begin
                  state    <= TS1;
                  out_data <= head_ts[15:8];
               end
            end
            TS1: begin
               if (accept) begin
                  state    <= PAY;
                  idx      <= '0;
                  out_data <= pay[0];
               end
            end
            PAY: begin
               if (accept) begin
                  if (idx == IDX_LAST) begin
                     idx <= '0;
                     if (more) begin
                        state    <= HDR;
                        out_data <= SYNC;
                     end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= 8'h00;
                     end
                  end else begin
                     idx      <= idx + IDX_ONE;
                     out_data <= pay[idx + IDX_ONE];
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_data  <= 8'h00;
               idx       <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_snn_spike_tx.sv
// Bench for snn_spike_tx: frame-queue reference model checked every cycle, plus directed scenarios.
module tb_snn_spike_tx;
   localparam int N     = 96;
   localparam int DEPTH = 4;
   localparam int NB    = N / 8;
   localparam int FB    = NB + 3;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [N-1:0]  spikes_vec = '0;
   logic          spike_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          clr_stat = 1'b0;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          overflow;
   logic [15:0]   drop_cnt;

   always #5 clk = ~clk;

   snn_spike_tx #(.N(N), .DEPTH(DEPTH), .TSW(16)) dut (
      .clk(clk), .rstn(rstn), .spikes_vec(spikes_vec), .spike_valid(spike_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow), .drop_cnt(drop_cnt), .clr_stat(clr_stat)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a queue of pending frames, the byte position in the head frame,
   // and whether the link is currently presenting a byte.
   logic [15:0]  m_ts_q [$];
   logic [N-1:0] m_row_q [$];
   int           m_pos;
   bit           m_vld;
   logic [15:0]  m_tsc;
   bit           m_ov;
   logic [15:0]  m_dc;
   bit           prev_stall;
   logic [7:0]   prev_data;
   logic [7:0]   rx_log [$];
   int           n_vld;

   function automatic logic [7:0] frame_byte(input logic [15:0] t, input logic [N-1:0] r, input int k);
      logic [N-1:0] s;
      s = r >> (8 * (k - 3));
      if (k == 0) return 8'hA5;
      if (k == 1) return t[7:0];
      if (k == 2) return t[15:8];
      return s[7:0];
   endfunction

   task automatic model_reset();
      m_ts_q.delete();
      m_row_q.delete();
      m_pos = 0;
      m_vld = 0;
      m_tsc = 0;
      m_ov = 0;
      m_dc = 0;
      prev_stall = 0;
   endtask

   task automatic check_outputs();
      chk("out_valid", out_valid, m_vld);
      if (m_vld) begin
         if (m_ts_q.size() == 0) chk("model_head", 0, 1);
         else chk("out_data", out_data, frame_byte(m_ts_q[0], m_row_q[0], m_pos));
      end
      chk("overflow", overflow, m_ov);
      chk("drop_cnt", drop_cnt, m_dc);
      if (prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid) n_vld++;
      if (out_valid && out_ready) rx_log.push_back(out_data);
   endtask

   task automatic model_edge(input bit sv, input logic [N-1:0] row, input bit rdy, input bit clr);
      bit hs, popped, keep, pushed, dropped;
      int remain;
      hs = m_vld && rdy;
      popped = hs && (m_pos == FB - 1);
`ifdef SNN_TX_SKIP_EMPTY_EN
      keep = sv && (row != '0);
`else
      keep = sv;
`endif
      pushed = 0;
      dropped = 0;
      if (keep) begin
         if (m_ts_q.size() < DEPTH || popped) pushed = 1;
         else dropped = 1;
      end
      if (hs) m_pos++;
      if (popped) begin
         void'(m_ts_q.pop_front());
         void'(m_row_q.pop_front());
         m_pos = 0;
      end
      remain = m_ts_q.size();
      if (pushed) begin
         m_ts_q.push_back(m_tsc);
         m_row_q.push_back(row);
      end
      if (sv) m_tsc++;
      if (clr) begin
         m_ov = 0;
         m_dc = 0;
      end
      if (dropped) begin
         m_ov = 1;
         if (m_dc != 16'hFFFF) m_dc++;
      end
      // A queued frame starts one edge after it is seen; a frame arriving at a pop follows immediately.
      m_vld = (remain > 0) || (popped && pushed);
   endtask

   task automatic cycle(input bit sv, input logic [N-1:0] row, input bit rdy, input bit clr);
      spike_valid = sv;
      spikes_vec = row;
      out_ready = rdy;
      clr_stat = clr;
      @(negedge clk);
      check_outputs();
      model_edge(sv, row, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit rnd, input int budget);
      int k;
      k = 0;
      while ((m_vld || m_ts_q.size() != 0 || out_valid) && k < budget) begin
         cycle(0, '0, rnd ? ($urandom_range(0, 2) != 0) : 1'b1, 0);
         k++;
      end
      chk("drain_budget", k < budget, 1);
   endtask

   task automatic do_reset();
      spike_valid = 0;
      out_ready = 0;
      clr_stat = 0;
      rstn = 0;
      @(posedge clk);
      #1;
      rstn = 1;
      model_reset();
      rx_log.delete();
   endtask

   function automatic logic [N-1:0] rand_row();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [N-1:0] row;
      logic [N-1:0] rows2 [3];
      bit fired;
      int k;

      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      do_reset();

      // Single row, neurons 0 and 95 firing, full-rate ready.
      row = '0;
      row[0] = 1'b1;
      row[N-1] = 1'b1;
      n_vld = 0;
      cycle(1, row, 1, 0);
      chk("lat_before_e1", out_valid, 0);
      cycle(0, '0, 1, 0);
      chk("lat_e1_valid", out_valid, 1);
      chk("lat_e1_sync", out_data, 8'hA5);
      repeat (20) cycle(0, '0, 1, 0);
      chk("t1_valid_cycles", n_vld, FB);
      chk("t1_len", rx_log.size(), FB);
      if (rx_log.size() == FB) begin
         for (int i = 0; i < FB; i++) begin
            chk("t1_byte", rx_log[i],
                (i == 0) ? 8'hA5 : (i == 3) ? 8'h01 : (i == FB - 1) ? 8'h80 : 8'h00);
         end
      end

      // Three frames under random backpressure.
      do_reset();
      for (int f = 0; f < 3; f++) begin
         rows2[f] = rand_row();
         cycle(1, rows2[f], $urandom_range(0, 1), 0);
         repeat ($urandom_range(1, 6)) cycle(0, '0, $urandom_range(0, 1), 0);
      end
      drain(1, 400);
      chk("bp_len", rx_log.size(), 3 * FB);
      if (rx_log.size() == 3 * FB) begin
         for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FB; i++) begin
               chk("bp_byte", rx_log[f*FB + i], frame_byte(16'(f), rows2[f], i));
            end
         end
      end

      // Overflow: six rows into a four-deep FIFO with the link stalled.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1, rand_row() | 96'h1, 0, 0);
      repeat (3) cycle(0, '0, 0, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drop_cnt", drop_cnt, 2);
      drain(0, 200);
      chk("ovf_len", rx_log.size(), 4 * FB);
      if (rx_log.size() == 4 * FB) begin
         for (int f = 0; f < 4; f++) chk("ovf_ts", {rx_log[f*FB + 2], rx_log[f*FB + 1]}, f);
      end
      cycle(0, '0, 1, 1);
      chk("clr_overflow", overflow, 0);
      chk("clr_drop_cnt", drop_cnt, 0);

      // Full FIFO with a strobe on the cycle the head's last byte is accepted.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1, rand_row(), 0, 0);
      fired = 0;
      k = 0;
      while (!fired && k < 100) begin
         if (m_vld && m_pos == FB - 1 && m_ts_q.size() == DEPTH) begin
            cycle(1, rand_row(), 1, 0);
            fired = 1;
         end else begin
            cycle(0, '0, 1, 0);
         end
         k++;
      end
      chk("fullpop_fired", fired, 1);
      chk("fullpop_drop_cnt", drop_cnt, 0);
      drain(0, 300);
      chk("fullpop_len", rx_log.size(), 5 * FB);
      if (rx_log.size() == 5 * FB) chk("fullpop_last_ts", rx_log[4*FB + 1], 4);

      // Reset in the middle of a frame, with a second frame queued behind it.
      do_reset();
      cycle(1, rand_row(), 1, 0);
      cycle(1, rand_row(), 1, 0);
      k = 0;
      while (rx_log.size() < 5 && k < 50) begin
         cycle(0, '0, 1, 0);
         k++;
      end
      chk("midrst_reached", rx_log.size(), 5);
      rstn = 0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      @(posedge clk);
      #1;
      rstn = 1;
      model_reset();
      rx_log.delete();
      row = rand_row();
      cycle(1, row, 1, 0);
      drain(0, 100);
      chk("midrst_len", rx_log.size(), FB);
      if (rx_log.size() == FB) chk("midrst_ts", {rx_log[2], rx_log[1]}, 0);

`ifdef SNN_TX_SKIP_EMPTY_EN
      do_reset();
      cycle(1, '0, 1, 0);
      cycle(1, rand_row() | 96'h1, 1, 0);
      cycle(1, '0, 1, 0);
      cycle(1, rand_row() | 96'h1, 1, 0);
      drain(0, 200);
      chk("skip_len", rx_log.size(), 2 * FB);
      if (rx_log.size() == 2 * FB) begin
         chk("skip_ts_a", rx_log[1], 1);
         chk("skip_ts_b", rx_log[FB + 1], 3);
      end
`endif

      // Random traffic, stalls, zero rows and statistic clears.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         row = ($urandom_range(0, 3) == 0) ? '0 : rand_row();
         cycle($urandom_range(0, 5) == 0, row, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      end
      drain(0, 400);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
